// File: rtl/keypad_scanner.sv
// Column-scanning front end for a 4x4 active-low matrix keypad.
// Synchronises the rows, debounces press and release, and reports the confirmed key.
module keypad_scanner #(
  parameter int SCAN_CNT     = 1000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_CNT = (SCAN_CNT > DEBOUNCE_CNT) ? SCAN_CNT : DEBOUNCE_CNT;
  localparam int CW      = $clog2(MAX_CNT);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CNT - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  function automatic logic [3:0] col_decode(input logic [1:0] idx);
    logic [3:0] drive;
    case (idx)
      2'd0:    drive = 4'b1110;
      2'd1:    drive = 4'b1101;
      2'd2:    drive = 4'b1011;
      2'd3:    drive = 4'b0111;
      default: drive = 4'b1110;
    endcase
    return drive;
  endfunction

  // Lowest low row wins when several rows are pulled down together.
  function automatic logic [1:0] first_low(input logic [3:0] pat);
    logic [1:0] idx;
    if (!pat[0]) begin
      idx = 2'd0;
    end else if (!pat[1]) begin
      idx = 2'd1;
    end else if (!pat[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    logic [CW-1:0] n;
    if (c == CNT_SAT) begin
      n = c;
    end else begin
      n = c + CNT_ONE;
    end
    return n;
  endfunction

  logic [3:0]    sync1_q, row_sync_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    pat_q, pat_d;

  logic [3:0]    col_out_q, col_out_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  // Two-flop synchroniser for the asynchronous row lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      sync1_q    <= row_in;
      row_sync_q <= sync1_q;
    end
  end

  // FSM state, shared counter, column index and latched row pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      cnt_q     <= CNT_ZERO;
      col_idx_q <= 2'd0;
      pat_q     <= 4'hF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_idx_q <= col_idx_d;
      pat_q     <= pat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_idx_d = col_idx_q;
    pat_d     = pat_q;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = CNT_ZERO;
          if (row_sync_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            pat_d   = row_sync_q;
            state_d = ST_DEBOUNCE;
          end
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      ST_DEBOUNCE: begin
        if (row_sync_q != pat_q) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_PRESSED;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      ST_PRESSED: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Any low row, including a different key, restarts the release window.
        if (row_sync_q != 4'hF) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d     = CNT_ZERO;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_SCAN;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      default: begin
        cnt_d     = CNT_ZERO;
        col_idx_d = 2'd0;
        pat_d     = 4'hF;
        state_d   = ST_SCAN;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it
  always_comb begin
    col_out_d   = col_decode(col_idx_d);
    key_valid_d = (state_d == ST_PRESSED);
    key_held_d  = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    if (state_d == ST_PRESSED) begin
      row_d = first_low(pat_q);
      col_d = col_idx_q;
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_out_q   <= 4'b1110;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_out_q   <= col_out_d;
      row_q       <= row_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_out   = col_out_q;
  assign row       = row_q;
  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 matrix keypad model
// (SCAN_CNT=4, DEBOUNCE_CNT=8).
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [1:0] row;
  logic [1:0] col;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;  // keys[r*4+c] = key (r,c) pressed
  int          n_checks;
  int          n_pass;
  int          vcount;

  keypad_scanner #(
    .SCAN_CNT    (4),
    .DEBOUNCE_CNT(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a pressed key shorts its row to its column when that column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Count key_valid pulses
  initial vcount = 0;
  always @(posedge clk) begin
    if (key_valid) vcount <= vcount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (key_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_held_low(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (!key_held) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [3:0] exp_col(input int idx);
    logic [3:0] v;
    v = 4'hF;
    v[idx] = 1'b0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int lat;
    int bad;
    n_checks = 0;
    n_pass   = 0;
    keys     = 16'h0000;
    rst_n    = 1'b0;
    tick(2);

    chk("rst_col_out",   col_out,   4'b1110);
    chk("rst_row",       row,       2'd0);
    chk("rst_col",       col,       2'd0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_held",  key_held,  1'b0);

    // Idle wrap: each column held 4 cycles, wrapping back to column 0
    rst_n = 1'b1;
    v0 = vcount;
    for (int k = 0; k < 40; k++) begin
      chk("idle_col", col_out, exp_col((k / 4) % 4));
      tick(1);
    end
    chk("idle_valid", vcount - v0, 0);

    // Clean press of key (2,1)
    keys = 16'h0000;
    do_reset();
    keys[9] = 1'b1;
    v0 = vcount;
    wait_valid(100, lat);
    chk("press_lat",     lat,      16);
    chk("press_row",     row,      2'd2);
    chk("press_col",     col,      2'd1);
    chk("press_held",    key_held, 1'b1);
    chk("press_col_out", col_out,  4'b1101);
    tick(1);
    chk("press_pulse_w", key_valid, 1'b0);
    bad = 0;
    for (int i = 0; i < 43; i++) begin
      if (col_out != 4'b1101 || !key_held) bad++;
      tick(1);
    end
    chk("press_hold", bad, 0);
    keys = 16'h0000;
    wait_held_low(40, lat);
    chk("release_lat",     lat,     10);
    chk("release_col_out", col_out, 4'b1011);
    chk("release_row",     row,     2'd2);
    chk("release_col",     col,     2'd1);
    tick(2);
    chk("press_pulses", vcount - v0, 1);

    // Bounce on key (0,3): toggle every 3 cycles, then hold
    keys = 16'h0000;
    do_reset();
    v0 = vcount;
    for (int i = 0; i < 10; i++) begin
      keys[3] = (i % 2 == 0);
      tick(3);
    end
    keys[3] = 1'b1;
    chk("bounce_quiet", vcount - v0, 0);
    wait_valid(40, lat);
    chk("bounce_seen", (lat > 0 && lat <= 20), 1'b1);
    chk("bounce_row",  row, 2'd0);
    chk("bounce_col",  col, 2'd3);
    tick(10);
    chk("bounce_pulses", vcount - v0, 1);

    // Long hold of key (3,2)
    keys = 16'h0000;
    do_reset();
    keys[14] = 1'b1;
    v0 = vcount;
    wait_valid(100, lat);
    chk("hold_lat", lat, 20);
    chk("hold_row", row, 2'd3);
    chk("hold_col", col, 2'd2);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (!key_held) bad++;
      tick(1);
    end
    chk("hold_held",   bad,         0);
    chk("hold_pulses", vcount - v0, 1);
    keys = 16'h0000;
    wait_held_low(40, lat);
    chk("hold_release_lat", lat, 10);

    // Multi-row: keys (1,0) and (3,0) together
    keys = 16'h0000;
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    do_reset();
    v0 = vcount;
    wait_valid(100, lat);
    chk("multi_lat", lat, 12);
    chk("multi_row", row, 2'd1);
    chk("multi_col", col, 2'd0);
    keys[4] = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (!key_held) bad++;
      tick(1);
    end
    chk("multi_still_held", bad,         0);
    chk("multi_pulses",     vcount - v0, 1);

    // Asynchronous reset while key (3,0) is still held in release
    rst_n = 1'b0;
    #1;
    chk("mrst_col_out",   col_out,   4'b1110);
    chk("mrst_key_held",  key_held,  1'b0);
    chk("mrst_row",       row,       2'd0);
    chk("mrst_col",       col,       2'd0);
    chk("mrst_key_valid", key_valid, 1'b0);
    tick(2);
    rst_n = 1'b1;
    v0 = vcount;
    wait_valid(100, lat);
    chk("mrst_lat", lat, 12);
    chk("mrst_new_row", row, 2'd3);
    chk("mrst_new_col", col, 2'd0);
    tick(20);
    chk("mrst_pulses", vcount - v0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
